// File: rtl/tt_vector_player.sv
// Stimulus/response vector sequencer: plays stored stimuli, checks masked DUT responses.
// Optional VECTOR_LOOP_EN adds a loop input that replays the vector set without a gap.
module tt_vector_player #(
    parameter int IN_W = 8,
    parameter int OUT_W = 8,
    parameter int ADDR_W = 4,
    parameter int LATENCY = 1,
    parameter logic [IN_W-1:0] IDLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [IN_W-1:0]   ld_stim,
    input  logic [OUT_W-1:0]  ld_exp,
    input  logic [OUT_W-1:0]  ld_mask,
    input  logic              start,
`ifdef VECTOR_LOOP_EN
    input  logic              loop,
`endif
    input  logic [ADDR_W:0]   num_vec,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [2:0] LAT3 = 3'(LATENCY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic [ADDR_W-1:0] idx, idx_n, last, last_n;
    logic [2:0] dcnt, dcnt_n;
    logic issue, clr, wrap;
    logic [ADDR_W:0] nv_clamp, nv_m1;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] mask_mem [DEPTH];

    logic [OUT_W-1:0]  exp_p  [LATENCY+1];
    logic [OUT_W-1:0]  mask_p [LATENCY+1];
    logic [ADDR_W-1:0] idx_p  [LATENCY+1];
    logic [LATENCY:0]  v_p;
    logic hit;

`ifdef VECTOR_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    assign nv_clamp = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
    assign nv_m1 = nv_clamp - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            last  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            last  <= last_n;
            dcnt  <= dcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        dcnt_n  = dcnt;
        issue   = 1'b0;
        clr     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    clr    = 1'b1;
                    idx_n  = '0;
                    last_n = nv_m1[ADDR_W-1:0];
                    if (nv_clamp == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        issue   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (idx != last) begin
                    idx_n = idx + 1'b1;
                    issue = 1'b1;
                end else if (wrap) begin
                    idx_n = '0;
                    issue = 1'b1;
                end else if (LATENCY == 0) begin
                    state_n = DONE;
                end else begin
                    state_n = DRAIN;
                    dcnt_n  = LAT3 - 3'd1;
                end
            end
            DRAIN: begin
                if (dcnt == '0) state_n = DONE;
                else dcnt_n = dcnt - 3'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Memory is deliberately unreset; writes locked out during a run.
    always_ff @(posedge clk) begin
        if (ld_we && !busy) begin
            stim_mem[ld_addr] <= ld_stim;
            exp_mem[ld_addr]  <= ld_exp;
            mask_mem[ld_addr] <= ld_mask;
        end
    end

    // Stage 0 of the compare pipe is aligned with dut_in.
    always_ff @(posedge clk) begin
        exp_p[0]  <= exp_mem[idx_n];
        mask_p[0] <= mask_mem[idx_n];
        idx_p[0]  <= idx_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in <= IDLE_VAL;
            v_p[0] <= 1'b0;
        end else begin
            dut_in <= issue ? stim_mem[idx_n] : IDLE_VAL;
            v_p[0] <= issue;
        end
    end

    for (genvar g = 1; g <= LATENCY; g++) begin : g_pipe
        always_ff @(posedge clk) begin
            exp_p[g]  <= exp_p[g-1];
            mask_p[g] <= mask_p[g-1];
            idx_p[g]  <= idx_p[g-1];
        end
        always_ff @(posedge clk) begin
            if (rst) v_p[g] <= 1'b0;
            else v_p[g] <= v_p[g-1];
        end
    end

    assign hit = v_p[LATENCY] &&
        (|((dut_out ^ exp_p[LATENCY]) & mask_p[LATENCY]));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_cnt   <= '0;
            first_err <= '0;
        end else if (hit) begin
            if (err_cnt == '0) first_err <= idx_p[LATENCY];
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);
endmodule

// File: tb/tb_tt_vector_player.sv
// Directed bench for tt_vector_player: LATENCY 1 main instance plus
// LATENCY 0/3 instances and a deliberately mis-modelled LATENCY 2 instance.
module tb_tt_vector_player;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_we = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_stim = '0, ld_exp = '0, ld_mask = '0;
    logic start = 1'b0;
    logic loop = 1'b0;
    logic [4:0] num_vec = '0;

    logic [7:0] dut_in, din0, din3, din2;
    logic [7:0] m1, m3a, m3b, m3c, out0;
    logic busy, done, pass, busy0, done0, pass0;
    logic busy3, done3, pass3, busy2, done2, pass2;
    logic [4:0] err_cnt, err0, err3, err2;
    logic [3:0] first_err, fe0, fe3, fe2;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        m1  <= dut_in + 8'd1;
        m3a <= din3 + 8'd1;
        m3b <= m3a;
        m3c <= m3b;
    end
    assign out0 = din0 + 8'd1;

    tt_vector_player #(.LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_stim(ld_stim), .ld_exp(ld_exp), .ld_mask(ld_mask),
        .start(start),
`ifdef VECTOR_LOOP_EN
        .loop(loop),
`endif
        .num_vec(num_vec), .dut_in(dut_in), .dut_out(m1),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err(first_err));

    tt_vector_player #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_stim(ld_stim), .ld_exp(ld_exp), .ld_mask(ld_mask),
        .start(start),
`ifdef VECTOR_LOOP_EN
        .loop(1'b0),
`endif
        .num_vec(num_vec), .dut_in(din0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err(fe0));

    tt_vector_player #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_stim(ld_stim), .ld_exp(ld_exp), .ld_mask(ld_mask),
        .start(start),
`ifdef VECTOR_LOOP_EN
        .loop(1'b0),
`endif
        .num_vec(num_vec), .dut_in(din3), .dut_out(m3c),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .first_err(fe3));

    // Expects two cycles but is fed the one-cycle model.
    tt_vector_player #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_stim(ld_stim), .ld_exp(ld_exp), .ld_mask(ld_mask),
        .start(start),
`ifdef VECTOR_LOOP_EN
        .loop(1'b0),
`endif
        .num_vec(num_vec), .dut_in(din2), .dut_out(m1),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_err(fe2));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ld(input logic [3:0] a, input logic [7:0] s,
                      input logic [7:0] e, input logic [7:0] m);
        @(negedge clk);
        ld_we = 1'b1;
        ld_addr = a;
        ld_stim = s;
        ld_exp = e;
        ld_mask = m;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Returns at the negedge of cycle t0.
    task automatic go(input logic [4:0] nv);
        @(negedge clk);
        start = 1'b1;
        num_vec = nv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    function automatic logic [7:0] s16(input int k);
        return 8'(k * 37 + 5);
    endfunction

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_first", first_err, 0);
        check("rst_din", dut_in, 0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++)
            ld(4'(k), 8'(k + 1), 8'(k + 2), 8'hff);

        go(4);
        for (int k = 0; k < 4; k++) begin
            check("seq_din", dut_in, k + 1);
            check("seq_busy", busy, 1);
            @(negedge clk);
        end
        check("drain_din", dut_in, 0);
        check("drain_done", done, 0);
        @(negedge clk);
        check("t5_done", done, 1);
        check("t5_pass", pass, 1);
        check("t5_err", err_cnt, 0);

        ld(2, 8'h03, 8'h00, 8'hff);
        go(4);
        wait_done(20);
        check("bad_err", err_cnt, 1);
        check("bad_first", first_err, 2);
        check("bad_pass", pass, 0);

        ld(2, 8'h03, 8'h00, 8'h00);
        go(4);
        wait_done(20);
        check("mask_pass", pass, 1);
        ld(2, 8'h03, 8'h04, 8'hff);

        go(0);
        check("nv0_done", done, 1);
        check("nv0_pass", pass, 1);
        check("nv0_busy", busy, 0);
        check("nv0_din", dut_in, 0);

        for (int k = 0; k < 16; k++)
            ld(4'(k), s16(k), s16(k) + 8'd1, 8'hff);
        go(31);
        cnt = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (busy && dut_in != 0) cnt++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("nv31_count", cnt, 16);
        check("nv31_pass", pass, 1);
        check("l0_pass", pass0, 1);
        check("l3_pass", pass3, 1);
        check("l2_err", err2, 16);

        go(4);
        @(negedge clk);
        start = 1'b1;
        ld_we = 1'b1;
        ld_addr = 1;
        ld_stim = 8'hff;
        ld_exp = 8'h00;
        ld_mask = 8'hff;
        @(negedge clk);
        start = 1'b0;
        ld_we = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_t4_done", done, 0);
        @(negedge clk);
        check("mid_t5_done", done, 1);
        go(4);
        @(negedge clk);
        check("mem_kept", dut_in, s16(1));
        wait_done(20);
        check("mem_pass", pass, 1);

        go(4);
        repeat (2) @(negedge clk);
        check("pre_rst_din", dut_in, s16(2));
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_din", dut_in, 0);
        check("mrst_err", err_cnt, 0);
        rst = 1'b0;

`ifdef VECTOR_LOOP_EN
        for (int k = 0; k < 4; k++)
            ld(4'(k), 8'(k + 1), (k == 1) ? 8'h00 : 8'(k + 2), 8'hff);
        loop = 1'b1;
        go(4);
        for (int k = 0; k < 12; k++) begin
            check("loop_din", dut_in, (k % 4) + 1);
            if (k == 8) loop = 1'b0;
            @(negedge clk);
        end
        check("loop_end_din", dut_in, 0);
        wait_done(20);
        check("loop_err", err_cnt, 3);
        check("loop_first", first_err, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
